vec_mem_stage: RTL
==================

// Module: vec_mem_stage
// PURPOSE
//  Memory stage directly downstream of the vector ALU. It consumes ALU results: for VLD/VST/SST the result is the effective address.
//  Serializes 16 x 16-bit lanes onto a single-word data-memory port: VLD gathers 16 words, VST scatters 16, SST writes 1.
//  Registers every other op's result into the writeback slot. Handshaked on both sides; stalls upstream while a transfer runs.
// PARAMETERS
//  LANES    16  lanes per vector register
//  LANE_W   16  bits per lane (half-precision float / scalar word)
//  ADDR_W   16  data-memory word-address width
// PORTS
//  clk        in   1               clock; all state on rising edge
//  rst_n      in   1               asynchronous, active-low reset
//  in_valid   in   1               upstream op valid
//  in_ready   out  1               stage can accept op this cycle
//  opcode     in   4               ALU opcode (VADD=0,VDOT=1,SMUL=2,SST=3,VLD=4,VST=5,SLL=6,SLH=7,NOP=F)
//  alu_result in   LANES*LANE_W    ALU output; bits [ADDR_W-1:0] = address for SST/VLD/VST
//  st_data    in   LANES*LANE_W    store data; lane i = bits [16i+15:16i]
//  mem_addr   out  ADDR_W          word address
//  mem_re     out  1               read strobe
//  mem_we     out  1               write strobe
//  mem_wdata  out  LANE_W          write data
//  mem_rdata  in   LANE_W          read data, valid in cycle mem_rdy=1 with mem_re=1
//  mem_rdy    in   1               memory completes current access this cycle
//  out_valid  out  1               writeback data valid
//  out_ready  in   1               writeback accepts
//  out_opcode out  4               opcode of op in writeback slot
//  out_data   out  LANES*LANE_W    loaded vector or passed-through ALU result
// BEHAVIOUR
//  Reset: state IDLE, lane_idx=0, out_valid=0, out_data=0, out_opcode=NOP, mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
//  Reset mid-transfer aborts immediately; partial VLD data discarded, strobes drop asynchronously, no out_valid.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Op accepted on in_valid && in_ready.
//  States: IDLE, LOAD, STORE, DONE.
//   IDLE: VLD->LOAD, VST/SST->STORE, base=alu_result[ADDR_W-1:0], lane_idx=0; NOP dropped (no output);
//         other opcodes -> out_data=alu_result, out_opcode=opcode, out_valid=1 next cycle (latency 1).
//   LOAD: mem_re=1, mem_addr=base+lane_idx (mod 2^ADDR_W); on mem_rdy capture lane lane_idx, lane_idx++; after lane 15 -> DONE.
//   STORE: mem_we=1, mem_wdata=st_data lane lane_idx (latched at accept); SST is 1 transfer, VST 16; final mem_rdy -> DONE.
//   DONE: VLD sets out_valid with assembled vector; VST/SST set out_valid with out_data=0 (retire token); -> IDLE.
//  mem_rdy=0 holds address/strobe/data stable; stall length unbounded.
//  out_valid held with stable out_data/out_opcode until out_ready; new accept same cycle as out_ready allowed.
//  Address wrap: base=0xFFF8 VLD reads 0xFFF8..0xFFFF,0x0000..0x0007.
//  VLD/VST latency = 16 mem_rdy cycles + 1 (DONE) + 1 (out_valid); back-to-back zero-wait VLD = 18 cycles/op.
// CONFIGURATION
//  VMEM_ALIGN_CHK_EN defined: extra port misalign_err out 1. VLD/VST with base[3:0]!=0 perform no memory
//   access; next cycle out_valid=1, out_data=0, misalign_err=1 (held with out_valid). SST unchecked.
//  Undefined: port absent; any base accepted, wraps as above.
// STRUCTURE
//  Shared package vcpu_pkg: opcode localparams, LANES, LANE_W, ADDR_W, state encoding typedef.
//  Sub-module vmem_lane_buf: 256-bit lane register with lane_idx counter, write-lane and select-lane ports; used for
//   VLD assembly and VST disassembly. FSM, handshakes, address adder stay in vec_mem_stage.
// TESTING
//  VADD result 0x..1234, out_ready=1 -> out_valid next cycle, out_data=input, no mem strobes.
//  VLD base 0x0100, mem[0x100+i]=0x3C00+i, mem_rdy=1 -> 16 reads 0x100..0x10F, out_data lane i=0x3C00+i.
//  VST base 0xFFF8 with random mem_rdy stalls -> 16 writes 0xFFF8..0x0007, lane order, data stable across stalls.
//  SST addr 0x0020 st_data[15:0]=0xBEEF -> one write 0x0020=0xBEEF, retire token, in_ready back after out_ready.
//  out_ready=0 after SMUL -> out_valid held, in_ready=0, next op not accepted; release -> accepted same cycle.
//  rst_n low at lane 7 of VLD -> strobes drop immediately, out_valid=0; VMEM_ALIGN_CHK_EN: VLD base 0x0103 -> err=1, no reads.

Source files
------------

// File: rtl/vcpu_pkg.sv
// Shared vector-CPU definitions: lane geometry, opcode encodings, memory-stage FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vcpu_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int ADDR_W = 16;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_t;

endpackage

// File: rtl/vmem_lane_buf.sv
// Vector lane register with lane cursor: parallel load, per-lane write, selected-lane read.
// Latency: writes/loads visible the cycle after the enable; sel_dat/last are combinational from the cursor.
// Backpressure: none; the owner only pulses wr_en/adv when the memory completes an access.
module vmem_lane_buf
    import vcpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_en,
    input  logic [VEC_W-1:0]  load_dat,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] wr_dat,
    input  logic              adv,
    output logic [VEC_W-1:0]  vec,
    output logic [LANE_W-1:0] sel_dat,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
            idx <= '0;
        end else begin
            if (load_en)
                vec <= load_dat;
            else if (wr_en)
                vec[int'(idx)*LANE_W +: LANE_W] <= wr_dat;

            if (clr)
                idx <= '0;
            else if (wr_en || adv)
                idx <= idx + 1'b1;
        end
    end

    assign sel_dat = vec[int'(idx)*LANE_W +: LANE_W];
    assign last    = (idx == IDX_W'(LANES - 1));

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: serialises VLD/VST/SST lanes onto a one-word memory port, passes other ALU results through.
// Latency: pass-through 1 cycle; VLD/VST 16 mem_rdy cycles + 2; SST 1 mem_rdy cycle + 2.
// Backpressure: in_ready only in IDLE with the writeback slot free or draining; VMEM_ALIGN_CHK_EN adds misalign_err.
module vec_mem_stage
    import vcpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [VEC_W-1:0]  alu_result,
    input  logic [VEC_W-1:0]  st_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [LANE_W-1:0] mem_wdata,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [VEC_W-1:0]  out_data
`ifdef VMEM_ALIGN_CHK_EN
    ,
    output logic              misalign_err
`endif
);

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [3:0]        op_reg;
    logic              accept;
    logic              xfer_start;

    logic              buf_clr, buf_load, buf_wr, buf_adv;
    logic [VEC_W-1:0]  buf_vec;
    logic [LANE_W-1:0] buf_sel;
    logic [IDX_W-1:0]  lane_idx;
    logic              lane_last;

    logic              out_load;
    logic [VEC_W-1:0]  out_load_dat;
    logic [3:0]        out_load_op;
`ifdef VMEM_ALIGN_CHK_EN
    logic              out_load_err;
`endif

    vmem_lane_buf u_lane_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (buf_clr),
        .load_en  (buf_load),
        .load_dat (st_data),
        .wr_en    (buf_wr),
        .wr_dat   (mem_rdata),
        .adv      (buf_adv),
        .vec      (buf_vec),
        .sel_dat  (buf_sel),
        .idx      (lane_idx),
        .last     (lane_last)
    );

    always_comb begin
        state_nxt    = state;
        in_ready     = (state == ST_IDLE) && (!out_valid || out_ready);
        accept       = in_valid && in_ready;
        xfer_start   = 1'b0;
        buf_clr      = 1'b0;
        buf_load     = 1'b0;
        buf_wr       = 1'b0;
        buf_adv      = 1'b0;
        out_load     = 1'b0;
        out_load_dat = '0;
        out_load_op  = op_reg;
`ifdef VMEM_ALIGN_CHK_EN
        out_load_err = 1'b0;
`endif
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_VLD, OP_VST, OP_SST: begin
`ifdef VMEM_ALIGN_CHK_EN
                            // Misaligned vector ops retire immediately with no memory traffic.
                            if (opcode != OP_SST && alu_result[3:0] != 4'h0) begin
                                out_load     = 1'b1;
                                out_load_op  = opcode;
                                out_load_err = 1'b1;
                            end else
`endif
                            begin
                                xfer_start = 1'b1;
                                buf_clr    = 1'b1;
                                buf_load   = 1'b1;
                                state_nxt  = (opcode == OP_VLD) ? ST_LOAD : ST_STORE;
                            end
                        end
                        OP_NOP: ;
                        default: begin
                            out_load     = 1'b1;
                            out_load_dat = alu_result;
                            out_load_op  = opcode;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                mem_re   = 1'b1;
                mem_addr = base + ADDR_W'(lane_idx);
                if (mem_rdy) begin
                    buf_wr = 1'b1;
                    if (lane_last)
                        state_nxt = ST_DONE;
                end
            end
            ST_STORE: begin
                mem_we    = 1'b1;
                mem_addr  = base + ADDR_W'(lane_idx);
                mem_wdata = buf_sel;
                if (mem_rdy) begin
                    buf_adv = 1'b1;
                    if (op_reg == OP_SST || lane_last)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stores retire with an all-zero token; loads hand over the assembled vector.
                out_load     = 1'b1;
                out_load_dat = (op_reg == OP_VLD) ? buf_vec : '0;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            base   <= '0;
            op_reg <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (xfer_start) begin
                base   <= alu_result[ADDR_W-1:0];
                op_reg <= opcode;
            end
        end
    end

    // Writeback slot: a new result may overwrite only when the slot is empty or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_opcode   <= OP_NOP;
`ifdef VMEM_ALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
        end else if (out_load) begin
            out_valid    <= 1'b1;
            out_data     <= out_load_dat;
            out_opcode   <= out_load_op;
`ifdef VMEM_ALIGN_CHK_EN
            misalign_err <= out_load_err;
`endif
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
`ifdef VMEM_ALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
        end
    end

endmodule
